// File: rtl/dma_channel_sequencer.sv
// dma_channel_sequencer: multi-channel DMA arbiter with HRQ/HLDA handshake, SI..S4 transfer timing,
// per-channel address/count registers, terminal count and autoinitialise
module dma_channel_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 16,
  parameter int COUNT_W = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_CH-1:0]         DREQ,
  input  logic                      HLDA,
  input  logic                      rotatePri,
  input  logic [NUM_CH-1:0]         autoInit,
  input  logic                      loadEn,
  input  logic [$clog2(NUM_CH)-1:0] loadCh,
  input  logic [ADDR_W-1:0]         loadAddr,
  input  logic [COUNT_W-1:0]        loadCount,
  output logic                      HRQ,
  output logic [NUM_CH-1:0]         DACK,
  output logic                      AEN,
  output logic                      ADSTB,
  output logic [ADDR_W-1:0]         addrOut,
  output logic                      TC,
  output logic [NUM_CH-1:0]         tcStatus,
  output logic [5:0]                state
);
  localparam int CW = $clog2(NUM_CH);
  typedef enum logic [5:0] {
    SI = 6'b000001,
    SO = 6'b000010,
    S1 = 6'b000100,
    S2 = 6'b001000,
    S4 = 6'b100000
  } st_t;
  st_t st, st_nx;
  logic [NUM_CH-1:0] en, req;
  logic [ADDR_W-1:0] base_addr [NUM_CH];
  logic [ADDR_W-1:0] cur_addr [NUM_CH];
  logic [COUNT_W-1:0] base_cnt [NUM_CH];
  logic [COUNT_W-1:0] cur_cnt [NUM_CH];
  logic [CW-1:0] win, hi, start, pick;
  logic any_req, xfer, reload;
  assign req = DREQ & en;
  assign start = rotatePri ? hi : '0;
  // search starts at the current highest-priority channel and wraps around
  always_comb begin
    pick = '0;
    any_req = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (!any_req && req[CW'((int'(start) + i) % NUM_CH)]) begin
        any_req = 1'b1;
        pick = CW'((int'(start) + i) % NUM_CH);
      end
  end
  always_comb
    st_nx = (st == SI) ? (any_req ? SO : SI) :
            (st == SO) ? (!DREQ[win] ? SI : (HLDA ? S1 : SO)) :
            (st == S1) ? S2 :
            (st == S2) ? S4 : SI;
  assign xfer = st == S2 || st == S4;
  assign HRQ = st != SI;
  assign AEN = st == S1 || xfer;
  assign ADSTB = st == S1;
  assign DACK = xfer ? {{(NUM_CH-1){1'b0}}, 1'b1} << win : '0;
  assign addrOut = AEN ? cur_addr[win] : '0;
  assign TC = st == S4 && cur_cnt[win] == '0;
  assign reload = TC && autoInit[win];
  assign state = st;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st <= SI;
      en <= '0;
      win <= '0;
      hi <= '0;
      tcStatus <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        base_addr[i] <= '0;
        cur_addr[i] <= '0;
        base_cnt[i] <= '0;
        cur_cnt[i] <= '0;
      end
    end else begin
      st <= st_nx;
      if (st == SI) win <= pick;
      if (st == SI && loadEn) begin
        en[loadCh] <= 1'b1;
        base_addr[loadCh] <= loadAddr;
        cur_addr[loadCh] <= loadAddr;
        base_cnt[loadCh] <= loadCount;
        cur_cnt[loadCh] <= loadCount;
        tcStatus[loadCh] <= 1'b0;
      end
      if (st == S4) begin
        hi <= (win == CW'(NUM_CH - 1)) ? '0 : win + 1'b1;
        cur_addr[win] <= reload ? base_addr[win] : cur_addr[win] + 1'b1;
        cur_cnt[win] <= reload ? base_cnt[win] : cur_cnt[win] - 1'b1;
        if (TC) begin
          tcStatus[win] <= 1'b1;
          en[win] <= autoInit[win];
        end
      end
    end
  end
endmodule

// File: tb/tb_dma_channel_sequencer.sv
// tb_dma_channel_sequencer: directed stimulus, per-cycle comparison against a phase-level behavioural model
module tb_dma_channel_sequencer;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst, hlda, rotate, load_en, hrq, aen, adstb, tc;
  logic [N-1:0] dreq, auto_init, dack, tc_status;
  logic [1:0] load_ch;
  logic [15:0] load_addr, load_count, addr_out;
  logic [5:0] st;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  dma_channel_sequencer #(.NUM_CH(N), .ADDR_W(16), .COUNT_W(16)) dut (
    .CLK(clk), .RESET(rst), .DREQ(dreq), .HLDA(hlda), .rotatePri(rotate),
    .autoInit(auto_init), .loadEn(load_en), .loadCh(load_ch), .loadAddr(load_addr),
    .loadCount(load_count), .HRQ(hrq), .DACK(dack), .AEN(aen), .ADSTB(adstb),
    .addrOut(addr_out), .TC(tc), .tcStatus(tc_status), .state(st)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: phase 0 idle, 1 hold requested, 2..4 the three transfer cycles
  int m_phase = 0, m_win = 0, m_hi = 0, m_en = 0, m_tcs = 0;
  int m_ba[N], m_ca[N], m_bc[N], m_cc[N];

  initial forever begin
    int start, pick, ch;
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_win = 0; m_hi = 0; m_en = 0; m_tcs = 0;
      for (int i = 0; i < N; i++) begin m_ba[i] = 0; m_ca[i] = 0; m_bc[i] = 0; m_cc[i] = 0; end
    end else if (m_phase == 0) begin
      start = rotate ? m_hi : 0;
      pick = -1;
      for (int k = 0; k < N; k++) begin
        ch = (start + k) % N;
        if (pick < 0 && ((int'(dreq) & m_en) >> ch) % 2 == 1) pick = ch;
      end
      if (load_en) begin
        ch = int'(load_ch);
        m_en = m_en | (1 << ch);
        m_tcs = m_tcs & ~(1 << ch);
        m_ba[ch] = int'(load_addr); m_ca[ch] = int'(load_addr);
        m_bc[ch] = int'(load_count); m_cc[ch] = int'(load_count);
      end
      if (pick >= 0) begin m_win = pick; m_phase = 1; end
    end else if (m_phase == 1)
      m_phase = ((int'(dreq) >> m_win) % 2 == 0) ? 0 : (hlda ? 2 : 1);
    else if (m_phase < 4)
      m_phase = m_phase + 1;
    else begin
      if (m_cc[m_win] == 0) begin
        m_tcs = m_tcs | (1 << m_win);
        if (auto_init[m_win[1:0]]) begin
          m_ca[m_win] = m_ba[m_win]; m_cc[m_win] = m_bc[m_win];
        end else begin
          m_en = m_en & ~(1 << m_win);
          m_ca[m_win] = (m_ca[m_win] + 1) % 65536; m_cc[m_win] = 65535;
        end
      end else begin
        m_ca[m_win] = (m_ca[m_win] + 1) % 65536; m_cc[m_win] = m_cc[m_win] - 1;
      end
      m_hi = (m_win + 1) % N;
      m_phase = 0;
    end
  end

  initial forever begin
    int es;
    @(posedge clk);
    #2;
    es = (m_phase == 0) ? 1 : (m_phase == 1) ? 2 : (m_phase == 2) ? 4 : (m_phase == 3) ? 8 : 32;
    chk("m_state", 32'(st), 32'(es));
    chk("m_hrq", 32'(hrq), 32'(m_phase != 0));
    chk("m_aen", 32'(aen), 32'(m_phase >= 2));
    chk("m_adstb", 32'(adstb), 32'(m_phase == 2));
    chk("m_dack", 32'(dack), (m_phase >= 3) ? 32'(1 << m_win) : 32'd0);
    chk("m_addr", 32'(addr_out), (m_phase >= 2) ? 32'(m_ca[m_win]) : 32'd0);
    chk("m_tc", 32'(tc), 32'(m_phase == 4 && m_cc[m_win] == 0));
    chk("m_tcstat", 32'(tc_status), 32'(m_tcs));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic load(input int ch, input int a, input int c);
    @(negedge clk);
    load_en = 1'b1; load_ch = 2'(ch); load_addr = 16'(a); load_count = 16'(c);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic wait_state(input logic [5:0] s);
    for (int i = 0; i < 40 && st !== s; i++) @(negedge clk);
    if (st !== s) chk("wait_timeout", 32'(st), 32'(s));
  endtask

  task automatic expect_pass(input string name, input int a, input int d, input int t);
    wait_state(6'b000100);
    chk({name, "_addr"}, 32'(addr_out), 32'(a));
    @(negedge clk);
    chk({name, "_dack"}, 32'(dack), 32'(d));
    @(negedge clk);
    chk({name, "_s4"}, 32'(st), 32'h20);
    chk({name, "_tc"}, 32'(tc), 32'(t));
  endtask

  initial begin
    rst = 1'b1; hlda = 1'b0; rotate = 1'b0; load_en = 1'b0; load_ch = '0;
    load_addr = '0; load_count = '0; dreq = '0; auto_init = '0;
    cyc(2);
    rst = 1'b0;
    chk("rst_state", 32'(st), 32'h01);
    chk("rst_hrq", 32'(hrq), 32'h0);
    chk("rst_tcstat", 32'(tc_status), 32'h0);
    // single channel, two transfers ending in terminal count
    hlda = 1'b1;
    load(0, 'h1000, 1);
    dreq = 4'b0001;
    expect_pass("t2_p1", 'h1000, 'b0001, 0);
    expect_pass("t2_p2", 'h1001, 'b0001, 1);
    cyc(4);
    chk("t2_disabled", 32'(st), 32'h01);
    chk("t2_tcstat", 32'(tc_status), 32'h1);
    dreq = '0;
    // reset in the middle of S2
    load(1, 'h2000, 5);
    dreq = 4'b0010;
    wait_state(6'b001000);
    rst = 1'b1; dreq = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("t1_state", 32'(st), 32'h01);
    chk("t1_dack", 32'(dack), 32'h0);
    chk("t1_hrq", 32'(hrq), 32'h0);
    chk("t1_aen", 32'(aen), 32'h0);
    chk("t1_tcstat", 32'(tc_status), 32'h0);
    // fixed priority
    for (int k = 0; k < N; k++) load(k, 'h4000 + k * 'h100, 'h100);
    dreq = 4'b1110;
    expect_pass("t3_a", 'h4100, 'b0010, 0);
    dreq = 4'b1111;
    expect_pass("t3_b", 'h4000, 'b0001, 0);
    dreq = '0;
    cyc(3);
    // rotating priority
    do_reset();
    for (int k = 0; k < N; k++) load(k, 'h5000 + k * 'h10, 'h20);
    rotate = 1'b1;
    dreq = 4'b1111;
    expect_pass("t4_0", 'h5000, 'b0001, 0);
    expect_pass("t4_1", 'h5010, 'b0010, 0);
    expect_pass("t4_2", 'h5020, 'b0100, 0);
    expect_pass("t4_3", 'h5030, 'b1000, 0);
    expect_pass("t4_4", 'h5001, 'b0001, 0);
    dreq = '0; rotate = 1'b0;
    cyc(3);
    // hold request never acknowledged, then request withdrawn
    hlda = 1'b0;
    dreq = 4'b0100;
    wait_state(6'b000010);
    for (int i = 0; i < 8; i++) begin
      chk("t5_so", 32'(st), 32'h02);
      chk("t5_nodack", 32'(dack), 32'h0);
      @(negedge clk);
    end
    dreq = '0;
    @(negedge clk);
    chk("t5_si", 32'(st), 32'h01);
    chk("t5_hrq", 32'(hrq), 32'h0);
    chk("t5_dack", 32'(dack), 32'h0);
    hlda = 1'b1;
    // autoinitialise with a single-word count
    do_reset();
    auto_init = 4'b0100;
    load(2, 'h00FF, 0);
    dreq = 4'b0100;
    expect_pass("t6_p1", 'h00FF, 'b0100, 1);
    expect_pass("t6_p2", 'h00FF, 'b0100, 1);
    expect_pass("t6_p3", 'h00FF, 'b0100, 1);
    dreq = '0;
    cyc(3);
    chk("t6_tcstat", 32'(tc_status), 32'h4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
